eth_phy_10g_rx_gearbox: RTL and testbench
=========================================

// Module: eth_phy_10g_rx_gearbox
// PURPOSE
//  32:66 RX gearbox for 10GBASE-R. Sits between a 32-bit raw SERDES RX port and eth_phy_10g_rx_if.
//  Packs the raw bit stream into 66-bit blocks and presents each as {data[63:0], hdr[1:0]} with a valid strobe.
//  Executes single-bit slips requested by frame sync, so block alignment happens in fabric, not in the transceiver.
// PARAMETERS
//  IN_WIDTH    32  raw SERDES word width; only 32 supported; elaborate $error otherwise
//  DATA_WIDTH  64  block payload width; only 64 supported
//  HDR_WIDTH   2   sync header width; only 2 supported
// PORTS
//  clk                 in   1   single clock, all logic rising edge
//  rst_n               in   1   synchronous reset, active-low
//  serdes_rx_raw       in   32  raw RX bits; bit 0 is earliest on the wire
//  serdes_rx_raw_valid in   1   serdes_rx_raw holds a new word this cycle
//  serdes_rx_data      out  64  block payload = block bits [65:2]
//  serdes_rx_hdr       out  2   sync header = block bits [1:0]
//  serdes_rx_valid     out  1   one-cycle strobe per emitted block
//  serdes_rx_bitslip   in   1   slip-one-bit request (level or pulse; edge not required)
//  rx_block_count      out  32  blocks emitted (STATS option)
//  rx_slip_count       out  16  slips executed (STATS option)
// BEHAVIOUR
//  - State: buf_reg[127:0], cnt_reg[6:0] (valid bits in buf, 0..97), slip_pend_reg.
//  - Reset (rst_n=0 at clk edge): buf=0, cnt=0, slip_pend=0, data=0, hdr=0, valid=0, counters=0.
//  - Slip request: if serdes_rx_bitslip=1 and slip_pend=0, set slip_pend. Requests while pending are ignored, never queued.
//  - Each cycle with raw_valid=1:
//      tmp  = buf | (raw << cnt); tcnt = cnt + 32.
//      If slip_pend: tmp >>= 1, tcnt -= 1, clear slip_pend.
//      If tcnt >= 66: data/hdr <= tmp[65:2]/tmp[1:0], valid <= 1, buf <= tmp >> 66, cnt <= tcnt - 66.
//      Otherwise: buf <= tmp, cnt <= tcnt, valid <= 0.
//  - raw_valid=0: buf, cnt and slip_pend hold; valid <= 0; data/hdr hold their last value.
//  - Latency: a block is presented one clk after the raw word that completes it. At most one block per cycle.
//  - Steady state: exactly 16 blocks per 33 consecutive raw words. cnt sequence repeats every 33 words.
//  - cnt never exceeds 97, so buf bits above 97 are always 0. No overflow and no backpressure path.
//  - Simultaneous slip request and raw word: the request sets slip_pend. The slip applies on the next raw_valid, not the current one.
//  - Mid-operation reset discards all buffered bits. The first block after reset needs three raw words.
//  - data/hdr are only meaningful while valid=1. Downstream must qualify with valid.
// CONFIGURATION
//  ETH_PHY_RX_GEARBOX_STATS_EN defined:
//    rx_block_count increments on every valid and wraps at 2^32.
//    rx_slip_count increments on each executed slip and saturates at 16'hFFFF.
//    Both counters clear on reset.
//  Not defined: both outputs tied to 0; no counter flops are inferred.
// STRUCTURE
//  Shared package eth_phy_10g_pkg holds:
//    localparam BLOCK_WIDTH = 66
//    localparam GEARBOX_BUF_WIDTH = 128
//    typedef eth_block_t = struct {logic [63:0] data; logic [1:0] hdr;}
//  Single module. Shift/merge is inline combinational logic; no sub-module is warranted.
// TESTING
//  T1 reset: hold rst_n=0 three cycles with raw_valid=1 -> valid=0, data=0, hdr=0, counts=0 throughout.
//  T2 steady: 33 words carrying 16 blocks {payload=i, hdr=2'b01}, i=0..15 ->
//     exactly 16 valid strobes, payloads 0..15 in order, hdr=01 each, first strobe one clk after word 3.
//  T3 bitslip: prepend 1 garbage bit to the T2 stream; pulse bitslip once before word 0 ->
//     blocks realign, payloads 0..15 correct, rx_slip_count=1 (STATS on).
//  T4 slip flood: hold bitslip=1 for 10 cycles with raw_valid=1 ->
//     10 slips total, one per raw word, never two in one word; cnt stays within 0..97.
//  T5 gaps: T2 stream with raw_valid randomly deasserted about 50% ->
//     identical block sequence; valid never asserted in cycles after raw_valid=0.
//  T6 mid-op reset: rst_n=0 for one cycle after word 17, then restart the T2 stream ->
//     no stale block emitted; first post-reset payload = 0.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared constants and payload types for the 10GBASE-R PHY datapath.
//   BLOCK_WIDTH        : 66-bit block (64-bit payload + 2-bit sync header)
//   GEARBOX_BUF_WIDTH  : width of the RX gearbox bit accumulator
//   eth_block_t        : {data[63:0], hdr[1:0]}; hdr sits in the block LSBs
// ----------------------------------------------------------------------------
package eth_phy_10g_pkg;

  localparam int unsigned BLOCK_WIDTH       = 66;
  localparam int unsigned GEARBOX_BUF_WIDTH = 128;
  localparam int unsigned GEARBOX_CNT_WIDTH = 7;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
  } eth_block_t;

endpackage : eth_phy_10g_pkg

// File: rtl/eth_phy_10g_rx_gearbox.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_rx_gearbox
// 32:66 RX gearbox for 10GBASE-R. Accumulates raw SERDES words (bit 0 is the
// earliest bit on the wire) into 66-bit blocks and executes single-bit slips
// requested by frame sync, so block alignment is done in fabric.
//
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   synchronous active-low reset
//   serdes_rx_raw        in   raw 32-bit SERDES word
//   serdes_rx_raw_valid  in   serdes_rx_raw carries a new word
//   serdes_rx_bitslip    in   slip-one-bit request (level or pulse)
//   serdes_rx_data       out  block payload (block bits [65:2])
//   serdes_rx_hdr        out  sync header   (block bits [1:0])
//   serdes_rx_valid      out  one-cycle strobe per emitted block
//   rx_block_count       out  emitted blocks, wraps      (stats build only)
//   rx_slip_count        out  executed slips, saturates  (stats build only)
//
// Build option: define ETH_PHY_RX_GEARBOX_STATS_EN to enable the counters;
// otherwise both counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module eth_phy_10g_rx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   serdes_rx_raw,
  input  logic                  serdes_rx_raw_valid,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic                  serdes_rx_valid,
  input  logic                  serdes_rx_bitslip,
  output logic [31:0]           rx_block_count,
  output logic [15:0]           rx_slip_count
);

  localparam int unsigned BUF_W = GEARBOX_BUF_WIDTH;
  localparam int unsigned CNT_W = GEARBOX_CNT_WIDTH;

  // Only the 32/64/2 geometry is supported
  if (IN_WIDTH != 32) begin : g_bad_in_width
    $error("eth_phy_10g_rx_gearbox: IN_WIDTH must be 32");
  end
  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
  end

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_slip_pend;
  eth_block_t       r_block;
  logic             r_valid;

  logic [BUF_W-1:0] w_tmp_merge;
  logic [CNT_W-1:0] w_cnt_merge;
  logic [BUF_W-1:0] w_tmp;
  logic [CNT_W-1:0] w_tcnt;
  logic             w_slip_exec;
  logic             w_emit;
  logic             w_slip_pend_nxt;

  // Merge the new word above the buffered bits, then apply a pending slip.
  // cnt is at most 65 here, so cnt + 32 never leaves the 7-bit range.
  always_comb begin
    w_tmp_merge = r_buf | (BUF_W'(serdes_rx_raw) << r_cnt);
    w_cnt_merge = r_cnt + CNT_W'(IN_WIDTH);
    w_slip_exec = serdes_rx_raw_valid & r_slip_pend;
    w_tmp       = r_slip_pend ? (w_tmp_merge >> 1) : w_tmp_merge;
    w_tcnt      = w_cnt_merge - CNT_W'(r_slip_pend);
    w_emit      = serdes_rx_raw_valid && (w_tcnt >= CNT_W'(BLOCK_WIDTH));
  end

  // A slip consumed by this word re-arms only from the current request, so a
  // held request yields exactly one slip per raw word and never queues.
  always_comb begin
    w_slip_pend_nxt = r_slip_pend | serdes_rx_bitslip;
    if (w_slip_exec) begin
      w_slip_pend_nxt = serdes_rx_bitslip;
    end
  end

  // Accumulator, slip state and registered block output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_slip_pend <= 1'b0;
      r_block     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_slip_pend <= w_slip_pend_nxt;
      if (serdes_rx_raw_valid) begin
        if (w_emit) begin
          r_block <= w_tmp[BLOCK_WIDTH-1:0];
          r_buf   <= w_tmp >> BLOCK_WIDTH;
          r_cnt   <= w_tcnt - CNT_W'(BLOCK_WIDTH);
          r_valid <= 1'b1;
        end else begin
          r_buf <= w_tmp;
          r_cnt <= w_tcnt;
        end
      end
    end
  end

  assign serdes_rx_data  = r_block.data;
  assign serdes_rx_hdr   = r_block.hdr;
  assign serdes_rx_valid = r_valid;

`ifdef ETH_PHY_RX_GEARBOX_STATS_EN
  logic [31:0] r_block_count;
  logic [15:0] r_slip_count;

  // Block counter wraps; slip counter saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_block_count <= '0;
      r_slip_count  <= '0;
    end else begin
      if (w_emit) begin
        r_block_count <= r_block_count + 32'd1;
      end
      if (w_slip_exec && (r_slip_count != 16'hFFFF)) begin
        r_slip_count <= r_slip_count + 16'd1;
      end
    end
  end

  assign rx_block_count = r_block_count;
  assign rx_slip_count  = r_slip_count;
`else
  assign rx_block_count = 32'd0;
  assign rx_slip_count  = 16'd0;
`endif

endmodule : eth_phy_10g_rx_gearbox

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// ----------------------------------------------------------------------------
// tb_eth_phy_10g_rx_gearbox
// Directed bench for the 32:66 RX gearbox. Streams of known 66-bit blocks
// {payload=i, hdr=2'b01} are serialised into 32-bit words; emitted blocks are
// captured on the falling edge and compared against the known payloads.
// Counter expectations follow ETH_PHY_RX_GEARBOX_STATS_EN (zero when absent).
// ----------------------------------------------------------------------------
module tb_eth_phy_10g_rx_gearbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] serdes_rx_raw;
  logic        serdes_rx_raw_valid;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic        serdes_rx_valid;
  logic        serdes_rx_bitslip;
  logic [31:0] rx_block_count;
  logic [15:0] rx_slip_count;

  eth_phy_10g_rx_gearbox dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .serdes_rx_raw       (serdes_rx_raw),
    .serdes_rx_raw_valid (serdes_rx_raw_valid),
    .serdes_rx_data      (serdes_rx_data),
    .serdes_rx_hdr       (serdes_rx_hdr),
    .serdes_rx_valid     (serdes_rx_valid),
    .serdes_rx_bitslip   (serdes_rx_bitslip),
    .rx_block_count      (rx_block_count),
    .rx_slip_count       (rx_slip_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int gap_viol = 0;
  logic prev_v = 1'b0;
  logic prev_rst = 1'b0;

  logic [63:0] q_data[$];
  logic [1:0]  q_hdr[$];
  int          q_cyc[$];

  logic [1055:0] t2_bits;
  logic [1087:0] t3_bits;

`ifdef ETH_PHY_RX_GEARBOX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Capture emitted blocks; a strobe is legal only if the previous cycle
  // presented a raw word outside reset.
  always @(negedge clk) begin
    cyc++;
    if (serdes_rx_valid === 1'b1) begin
      q_data.push_back(serdes_rx_data);
      q_hdr.push_back(serdes_rx_hdr);
      q_cyc.push_back(cyc);
      if (!(prev_v && prev_rst)) gap_viol++;
    end
    prev_v   = serdes_rx_raw_valid;
    prev_rst = rst_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] raw, input logic v, input logic slip);
    @(posedge clk);
    #1;
    serdes_rx_raw       = raw;
    serdes_rx_raw_valid = v;
    serdes_rx_bitslip   = slip;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'd0, 1'b0, 1'b0);
  endtask

  // Let the previously driven input be sampled, then hold reset n cycles
  // while feeding garbage words.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n               = 1'b0;
    serdes_rx_raw       = $urandom;
    serdes_rx_raw_valid = 1'b1;
    serdes_rx_bitslip   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n               = 1'b1;
    serdes_rx_raw_valid = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_hdr.delete();
    q_cyc.delete();
  endtask

  task automatic check_blocks(input string tag, input int n);
    chk({tag, "_count"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), q_data[i], 64'(i));
      chk($sformatf("%s_hdr%0d", tag, i), 64'(q_hdr[i]), 64'd1);
    end
  endtask

  initial begin
    int w2_cyc;
    int gaps;
    logic [31:0] w;

    rst_n               = 1'b0;
    serdes_rx_raw       = 32'd0;
    serdes_rx_raw_valid = 1'b0;
    serdes_rx_bitslip   = 1'b0;
    w2_cyc              = 0;

    for (int i = 0; i < 16; i++) t2_bits[66*i +: 66] = {64'(i), 2'b01};
    t3_bits = {31'd0, t2_bits, 1'b1};

    // T1: reset held three cycles with raw words present
    serdes_rx_raw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t1_valid%0d", i), 64'(serdes_rx_valid), 64'd0);
      chk($sformatf("t1_data%0d", i), serdes_rx_data, 64'd0);
      chk($sformatf("t1_hdr%0d", i), 64'(serdes_rx_hdr), 64'd0);
      chk($sformatf("t1_bcnt%0d", i), 64'(rx_block_count), 64'd0);
      chk($sformatf("t1_scnt%0d", i), 64'(rx_slip_count), 64'd0);
      serdes_rx_raw = $urandom;
    end
    rst_n               = 1'b1;
    serdes_rx_raw_valid = 1'b0;
    clear_q();

    // T2: 33 words carry 16 blocks back to back
    for (int k = 0; k < 33; k++) begin
      w = t2_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
      if (k == 2) w2_cyc = cyc;
    end
    idle(2);
    check_blocks("t2", 16);
    if (q_cyc.size() > 0) chk("t2_first_lat", 64'(q_cyc[0]), 64'(w2_cyc + 2));
    chk("t2_idle_valid", 64'(serdes_rx_valid), 64'd0);
    chk("t2_hold_data", serdes_rx_data, 64'd15);
    chk("t2_bcnt", 64'(rx_block_count), STATS ? 64'd16 : 64'd0);

    // T3: one garbage bit in front, one slip pulse before word 0
    clear_q();
    drive($urandom, 1'b0, 1'b1);
    for (int k = 0; k < 34; k++) begin
      w = t3_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
    end
    idle(2);
    check_blocks("t3", 16);
    chk("t3_scnt", 64'(rx_slip_count), STATS ? 64'd1 : 64'd0);
    chk("t3_bcnt", 64'(rx_block_count), STATS ? 64'd32 : 64'd0);

    // T4: slip held for 10 raw words. 23 words minus 10 slipped bits is
    // exactly 11 blocks with nothing left over, so a clean stream follows.
    do_reset(1);
    clear_q();
    for (int k = 0; k < 23; k++) drive($urandom, 1'b1, k < 10);
    idle(2);
    chk("t4_flood_blocks", 64'(q_data.size()), 64'd11);
    chk("t4_scnt", 64'(rx_slip_count), STATS ? 64'd10 : 64'd0);
    clear_q();
    for (int k = 0; k < 33; k++) begin
      w = t2_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
    end
    idle(2);
    check_blocks("t4", 16);
    chk("t4_bcnt", 64'(rx_block_count), STATS ? 64'd27 : 64'd0);
    chk("t4_scnt_final", 64'(rx_slip_count), STATS ? 64'd10 : 64'd0);

    // T5: same stream with random idle cycles carrying garbage
    do_reset(1);
    clear_q();
    for (int k = 0; k < 33; k++) begin
      gaps = 0;
      while ($urandom_range(0, 1) == 1 && gaps < 3) begin
        drive($urandom, 1'b0, 1'b0);
        gaps++;
      end
      w = t2_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
    end
    idle(2);
    check_blocks("t5", 16);

    // T6: reset after word 17, then restart the stream
    do_reset(1);
    for (int k = 0; k < 18; k++) begin
      w = t2_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
    end
    do_reset(1);
    clear_q();
    chk("t6_rst_valid", 64'(serdes_rx_valid), 64'd0);
    chk("t6_rst_data", serdes_rx_data, 64'd0);
    for (int k = 0; k < 33; k++) begin
      w = t2_bits[32*k +: 32];
      drive(w, 1'b1, 1'b0);
    end
    idle(2);
    check_blocks("t6", 16);
    chk("t6_bcnt", 64'(rx_block_count), STATS ? 64'd16 : 64'd0);

    chk("valid_without_word", 64'(gap_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_eth_phy_10g_rx_gearbox
